// File: rtl/state_timing_gen_if.sv
// Bus between the timing state generator and its environment: READY/interrupt
// inputs, instruction-decode qualifiers and the registered T-state outputs.
interface state_timing_gen_if;
   logic       ready;
   logic       intr;
   logic       end_at_t3;
   logic       end_at_t4;
   logic       last_cycle;
   logic       halt;
   logic [2:0] state;
   logic [1:0] cycle;
   logic       int_ack;
   logic       int_pending;

   modport master (
      output ready, intr, end_at_t3, end_at_t4, last_cycle, halt,
      input  state, cycle, int_ack, int_pending
   );

   modport slave (
      input  ready, intr, end_at_t3, end_at_t4, last_cycle, halt,
      output state, cycle, int_ack, int_pending
   );
endinterface

// File: rtl/state_timing_gen.sv
// Processor T-state sequencer: walks T1/T1I..T5 per machine cycle, inserts WAIT
// on READY low, stops on HLT and acknowledges latched interrupts between instructions.
module state_timing_gen #(
   parameter int MAX_CYCLES = 3
) (
   input logic               clk,
   input logic               rst,
   state_timing_gen_if.slave bus
);

   typedef enum logic [2:0] {
      ST_WAIT    = 3'b000,
      ST_T2      = 3'b001,
      ST_T1      = 3'b010,
      ST_T1I     = 3'b011,
      ST_T3      = 3'b100,
      ST_T5      = 3'b101,
      ST_STOPPED = 3'b110,
      ST_T4      = 3'b111
   } state_t;

   localparam logic [1:0] CYCLE_LAST = 2'(MAX_CYCLES - 1);

   state_t     state_r;
   state_t     state_s;
   logic [1:0] cycle_r;
   logic [1:0] cycle_s;
   logic       cycle_end_s;
   logic       intr_q_r;
   logic       int_pending_r;
   logic       int_pending_s;
   logic       int_ack_r;

   // Next T-state and machine-cycle index
   always_comb begin
      state_s     = state_r;
      cycle_s     = cycle_r;
      cycle_end_s = 1'b0;
      case (state_r)
         ST_T1, ST_T1I: state_s = ST_T2;
         ST_T2, ST_WAIT: begin
            if (bus.ready) state_s = ST_T3;
            else           state_s = ST_WAIT;
         end
         ST_T3: begin
            if (bus.halt)           state_s     = ST_STOPPED;
            else if (bus.end_at_t3) cycle_end_s = 1'b1;
            else                    state_s     = ST_T4;
         end
         ST_T4: begin
            if (bus.end_at_t4) cycle_end_s = 1'b1;
            else               state_s     = ST_T5;
         end
         ST_T5: cycle_end_s = 1'b1;
         ST_STOPPED: begin
            if (int_pending_r) begin
               state_s = ST_T1I;
               cycle_s = 2'd0;
            end else begin
               state_s = ST_STOPPED;
            end
         end
         default: begin
            state_s = ST_T1;
            cycle_s = 2'd0;
         end
      endcase

      // Interrupts are only taken at an instruction boundary
      if (cycle_end_s) begin
         if (bus.last_cycle || (cycle_r == CYCLE_LAST)) begin
            cycle_s = 2'd0;
            state_s = int_pending_r ? ST_T1I : ST_T1;
         end else begin
            cycle_s = cycle_r + 2'd1;
            state_s = ST_T1;
         end
      end else begin
         cycle_s = cycle_s;
      end
   end

   // Interrupt request latch; a fresh edge wins over the clear on T1I entry
   always_comb begin
      int_pending_s = int_pending_r;
      if (bus.intr && !intr_q_r) begin
         int_pending_s = 1'b1;
      end else if (state_s == ST_T1I) begin
         int_pending_s = 1'b0;
      end else begin
         int_pending_s = int_pending_r;
      end
   end

   // Sequencer and interrupt registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_T1;
         cycle_r       <= 2'd0;
         intr_q_r      <= 1'b0;
         int_pending_r <= 1'b0;
         int_ack_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         cycle_r       <= cycle_s;
         intr_q_r      <= bus.intr;
         int_pending_r <= int_pending_s;
         int_ack_r     <= (state_s == ST_T1I);
      end
   end

   assign bus.state       = state_r;
   assign bus.cycle       = cycle_r;
   assign bus.int_ack     = int_ack_r;
   assign bus.int_pending = int_pending_r;

endmodule

// File: tb/tb_state_timing_gen.sv
// Scoreboard bench for state_timing_gen: each vector carries inputs for one clock
// and the outputs expected after that edge.
module tb_state_timing_gen;

   localparam logic [2:0] S_WAIT = 3'b000;
   localparam logic [2:0] S_T2   = 3'b001;
   localparam logic [2:0] S_T1   = 3'b010;
   localparam logic [2:0] S_T1I  = 3'b011;
   localparam logic [2:0] S_T3   = 3'b100;
   localparam logic [2:0] S_T5   = 3'b101;
   localparam logic [2:0] S_STOP = 3'b110;
   localparam logic [2:0] S_T4   = 3'b111;

   // inp bit order: {rst, ready, intr, end_at_t3, end_at_t4, last_cycle, halt}
   typedef struct packed {
      logic [6:0] inp;
      logic [6:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   vec_t       stim_q[$];
   logic [6:0] exp_q[$];

   state_timing_gen_if bus_if();

   state_timing_gen #(.MAX_CYCLES(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   function automatic void add(input logic [6:0] inp, input logic [2:0] st,
                               input logic [1:0] cy, input logic ack, input logic pend);
      vec_t v;
      v.inp = inp;
      v.exp = {st, cy, ack, pend};
      stim_q.push_back(v);
   endfunction

   task automatic apply(input vec_t v);
      {rst, bus_if.ready, bus_if.intr, bus_if.end_at_t3, bus_if.end_at_t4,
       bus_if.last_cycle, bus_if.halt} = v.inp;
      exp_q.push_back(v.exp);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] observed();
      return {bus_if.state, bus_if.cycle, bus_if.int_ack, bus_if.int_pending};
   endfunction

   task automatic test_reset();
      logic [6:0] e;
      vec_t v;
      int   n = 0;
      add(7'b1000000, S_T1, 2'd0, 1'b0, 1'b0);
      add(7'b0100000, S_T2, 2'd0, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         v = stim_q.pop_front();
         apply(v);
         e = exp_q.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("FAIL reset step %0d: got {st,cy,ack,pend}=%b want %b", n, observed(), e);
         end
         n++;
      end
   endtask

   task automatic test_basic();
      logic [6:0] e;
      vec_t v;
      int   n = 0;
      add(7'b1000000, S_T1, 2'd0, 1'b0, 1'b0);
      add(7'b0100010, S_T2, 2'd0, 1'b0, 1'b0);
      add(7'b0100010, S_T3, 2'd0, 1'b0, 1'b0);
      add(7'b0100010, S_T4, 2'd0, 1'b0, 1'b0);
      add(7'b0100010, S_T5, 2'd0, 1'b0, 1'b0);
      add(7'b0100010, S_T1, 2'd0, 1'b0, 1'b0);
      add(7'b0100010, S_T2, 2'd0, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         v = stim_q.pop_front();
         apply(v);
         e = exp_q.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("FAIL basic step %0d: got {st,cy,ack,pend}=%b want %b", n, observed(), e);
         end
         n++;
      end
   endtask

   task automatic test_wait();
      logic [6:0] e;
      vec_t v;
      int   n = 0;
      add(7'b1000000, S_T1, 2'd0, 1'b0, 1'b0);
      add(7'b0100000, S_T2, 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) add(7'b0000000, S_WAIT, 2'd0, 1'b0, 1'b0);
      add(7'b0100000, S_T3, 2'd0, 1'b0, 1'b0);
      add(7'b0101010, S_T1, 2'd0, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         v = stim_q.pop_front();
         apply(v);
         e = exp_q.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("FAIL wait step %0d: got {st,cy,ack,pend}=%b want %b", n, observed(), e);
         end
         n++;
      end
   endtask

   task automatic test_multicycle();
      logic [6:0] e;
      vec_t v;
      int   n = 0;
      add(7'b1000000, S_T1, 2'd0, 1'b0, 1'b0);
      add(7'b0100100, S_T2, 2'd0, 1'b0, 1'b0);
      add(7'b0100100, S_T3, 2'd0, 1'b0, 1'b0);
      add(7'b0100100, S_T4, 2'd0, 1'b0, 1'b0);
      add(7'b0100100, S_T1, 2'd1, 1'b0, 1'b0);
      add(7'b0101000, S_T2, 2'd1, 1'b0, 1'b0);
      add(7'b0101000, S_T3, 2'd1, 1'b0, 1'b0);
      add(7'b0101000, S_T1, 2'd2, 1'b0, 1'b0);
      add(7'b0101010, S_T2, 2'd2, 1'b0, 1'b0);
      add(7'b0101010, S_T3, 2'd2, 1'b0, 1'b0);
      add(7'b0101010, S_T1, 2'd0, 1'b0, 1'b0);
      // last_cycle held low: index saturates at 2 and wraps to 0
      for (int c = 0; c < 3; c++) begin
         add(7'b0101000, S_T2, 2'(c), 1'b0, 1'b0);
         add(7'b0101000, S_T3, 2'(c), 1'b0, 1'b0);
         add(7'b0101000, S_T1, 2'((c + 1) % 3), 1'b0, 1'b0);
      end
      while (stim_q.size() > 0) begin
         v = stim_q.pop_front();
         apply(v);
         e = exp_q.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("FAIL multicycle step %0d: got {st,cy,ack,pend}=%b want %b", n, observed(), e);
         end
         n++;
      end
   endtask

   task automatic test_interrupt();
      logic [6:0] e;
      vec_t v;
      int   n = 0;
      add(7'b1000000, S_T1,  2'd0, 1'b0, 1'b0);
      add(7'b0100100, S_T2,  2'd0, 1'b0, 1'b0);
      add(7'b0100100, S_T3,  2'd0, 1'b0, 1'b0);
      add(7'b0100100, S_T4,  2'd0, 1'b0, 1'b0);
      add(7'b0110100, S_T1,  2'd1, 1'b0, 1'b1);
      add(7'b0101010, S_T2,  2'd1, 1'b0, 1'b1);
      add(7'b0101010, S_T3,  2'd1, 1'b0, 1'b1);
      add(7'b0101010, S_T1I, 2'd0, 1'b1, 1'b0);
      add(7'b0101010, S_T2,  2'd0, 1'b0, 1'b0);
      add(7'b0111010, S_T3,  2'd0, 1'b0, 1'b1);
      add(7'b0101010, S_T1I, 2'd0, 1'b1, 1'b0);
      add(7'b0101010, S_T2,  2'd0, 1'b0, 1'b0);
      add(7'b0110110, S_T3,  2'd0, 1'b0, 1'b1);
      add(7'b0100110, S_T4,  2'd0, 1'b0, 1'b1);
      // new edge on the same clock as T1I entry keeps the request
      add(7'b0110110, S_T1I, 2'd0, 1'b1, 1'b1);
      add(7'b0111010, S_T2,  2'd0, 1'b0, 1'b1);
      add(7'b0111010, S_T3,  2'd0, 1'b0, 1'b1);
      add(7'b0111010, S_T1I, 2'd0, 1'b1, 1'b0);
      add(7'b0111010, S_T2,  2'd0, 1'b0, 1'b0);
      add(7'b0111010, S_T3,  2'd0, 1'b0, 1'b0);
      add(7'b0111010, S_T1,  2'd0, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         v = stim_q.pop_front();
         apply(v);
         e = exp_q.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("FAIL interrupt step %0d: got {st,cy,ack,pend}=%b want %b", n, observed(), e);
         end
         n++;
      end
   endtask

   task automatic test_halt();
      logic [6:0] e;
      vec_t v;
      int   n = 0;
      add(7'b1000000, S_T1, 2'd0, 1'b0, 1'b0);
      add(7'b0101000, S_T2, 2'd0, 1'b0, 1'b0);
      add(7'b0101000, S_T3, 2'd0, 1'b0, 1'b0);
      add(7'b0101000, S_T1, 2'd1, 1'b0, 1'b0);
      add(7'b0101000, S_T2, 2'd1, 1'b0, 1'b0);
      add(7'b0101001, S_T3, 2'd1, 1'b0, 1'b0);
      add(7'b0101001, S_STOP, 2'd1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         add(((i % 2) == 1) ? 7'b0101111 : 7'b0000000, S_STOP, 2'd1, 1'b0, 1'b0);
      add(7'b0010000, S_STOP, 2'd1, 1'b0, 1'b1);
      add(7'b0010000, S_T1I,  2'd0, 1'b1, 1'b0);
      add(7'b0000000, S_T2,   2'd0, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         v = stim_q.pop_front();
         apply(v);
         e = exp_q.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("FAIL halt step %0d: got {st,cy,ack,pend}=%b want %b", n, observed(), e);
         end
         n++;
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] e;
      vec_t v;
      int   n = 0;
      add(7'b1000000, S_T1,   2'd0, 1'b0, 1'b0);
      add(7'b0000000, S_T2,   2'd0, 1'b0, 1'b0);
      add(7'b0000000, S_WAIT, 2'd0, 1'b0, 1'b0);
      add(7'b0010000, S_WAIT, 2'd0, 1'b0, 1'b1);
      add(7'b1000000, S_T1,   2'd0, 1'b0, 1'b0);
      add(7'b0100001, S_T2,   2'd0, 1'b0, 1'b0);
      add(7'b0100001, S_T3,   2'd0, 1'b0, 1'b0);
      add(7'b0100001, S_STOP, 2'd0, 1'b0, 1'b0);
      add(7'b0010000, S_STOP, 2'd0, 1'b0, 1'b1);
      add(7'b1000000, S_T1,   2'd0, 1'b0, 1'b0);
      add(7'b0100010, S_T2,   2'd0, 1'b0, 1'b0);
      while (stim_q.size() > 0) begin
         v = stim_q.pop_front();
         apply(v);
         e = exp_q.pop_front();
         total++;
         if (observed() !== e) begin
            bad++;
            $display("FAIL reset_mid step %0d: got {st,cy,ack,pend}=%b want %b", n, observed(), e);
         end
         n++;
      end
   endtask

   initial begin
      rst               = 1'b1;
      bus_if.ready      = 1'b0;
      bus_if.intr       = 1'b0;
      bus_if.end_at_t3  = 1'b0;
      bus_if.end_at_t4  = 1'b0;
      bus_if.last_cycle = 1'b0;
      bus_if.halt       = 1'b0;
      test_reset();
      test_basic();
      test_wait();
      test_multicycle();
      test_interrupt();
      test_halt();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/state_timing_gen.md
Name: state_timing_gen

Overview:
- Processor timing state generator; drives the 3-bit `state` bus consumed by the scratchpad address selector and the other T-state-qualified datapath blocks.
- Sequences T1/T1I, T2, WAIT, T3, T4, T5 and STOPPED per machine cycle.
- Tracks the machine-cycle index within an instruction and handles READY wait insertion, HLT stop and interrupt acknowledge.

Parameters:
MAX_CYCLES, 3, maximum machine cycles per instruction; `cycle` saturates at MAX_CYCLES-1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
ready  input  1  external READY; low at T2 inserts WAIT states
intr  input  1  external interrupt request, level input, rising edge latched
end_at_t3  input  1  decode: current machine cycle ends after T3
end_at_t4  input  1  decode: current machine cycle ends after T4
last_cycle  input  1  decode: current machine cycle is the final one of the instruction
halt  input  1  decode: HLT executing; enter STOPPED after T3
state  output  3  current T-state, `STATE_* encoding
cycle  output  2  machine-cycle index within instruction, 0 = instruction fetch
int_ack  output  1  high exactly while state == T1I
int_pending  output  1  latched, not yet acknowledged interrupt

Behaviour:
- State encoding (fixed, matches `STATE_*` in common.svh): WAIT=000, T2=001, T1=010, T1I=011, T3=100, T5=101, STOPPED=110, T4=111.
- Reset (rst=1 at clk edge): state=T1, cycle=0, int_pending=0, int_ack=0, intr edge register=0. Reset wins over every other event, including mid-WAIT and STOPPED.
- All outputs registered; state advances one step per clk.
- Transitions:
  - T1 -> T2; T1I -> T2.
  - T2 -> T3 if ready=1, else WAIT.
  - WAIT -> T3 when ready=1, else stay WAIT; the wait length is unbounded.
  - T3: halt=1 -> STOPPED (halt has priority over end_at_t3); else end_at_t3=1 -> CYCLE_END; else T4.
  - T4: end_at_t4=1 -> CYCLE_END; else T5.
  - T5 -> CYCLE_END.
  - STOPPED: stay until int_pending=1, then -> T1I with cycle=0; ready, halt and decode inputs are ignored.
- CYCLE_END (a transition, not a state):
  - If last_cycle=1, or cycle==MAX_CYCLES-1: cycle <= 0; next state T1I if int_pending=1, else T1.
  - Otherwise: cycle <= cycle+1; next state T1. Interrupts are never taken mid-instruction.
- Decode inputs (end_at_t3, end_at_t4, last_cycle, halt) are sampled only in the state that uses them; they are don't-care elsewhere.
- Interrupt latch:
  - intr_q <= intr each clk.
  - int_pending set when intr=1 and intr_q=0.
  - int_pending cleared on the edge that enters T1I.
  - A rising edge in the same clk as T1I entry leaves int_pending=1, so the new request is kept.
  - A held-high intr produces only one request.
- int_ack registered alongside state: 1 in the cycle state==T1I, otherwise 0.
- Illegal state code: unreachable with 8 encodings used; the default branch forces T1, cycle=0.

Test Plan:
- Reset then ready=1, end_at_t3=0, end_at_t4=0, last_cycle=1 -> state sequence T1,T2,T3,T4,T5,T1,... (010,001,100,111,101,010); cycle stays 0.
- ready=0 for 3 clks while in T2 -> T2,WAIT,WAIT,WAIT,T3 once ready=1; T3 follows WAIT on the first clk with ready=1.
- 3-cycle instruction: last_cycle=0,0,1 with end_at_t3=1 on cycles 1 and 2 -> cycle 0,1,2,0; cycles 1 and 2 are T1,T2,T3 only. With MAX_CYCLES=3 and last_cycle held 0, cycle wraps 2->0.
- Pulse intr during T4 of cycle 0 of a 2-cycle instruction -> int_pending=1; next T1 of cycle 1 is plain T1; after the final cycle, state=T1I (011) with int_ack=1; int_pending clears the same edge.
- halt=1 at T3 -> STOPPED (110) held for 10 clks with ready toggling; intr rising edge -> T1I, cycle=0, then T2.
- Assert rst during WAIT and again during STOPPED -> next state T1, cycle=0, int_pending=0, int_ack=0.
